cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
- Miss-handling controller that sits between the pipeline's memory stage (I-side or D-side cache lookup) and the multi-cycle main memory.
- On a cache miss it stalls the pipeline and fetches the 16-byte block (8 x 16-bit words) holding the miss address. It issues one word read per cycle.
- Each returned word is written into the cache data array. After the last word arrives, the tag array is written.
- One instance per cache. It replaces the single-cycle memory path for that cache.

Parameters:
- ADDR_W, 16, byte address width.
- WORDS, 8, words per block. Must be a power of 2. The word offset field is log2(WORDS) bits, located at address bits [log2(WORDS):1].

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- miss_detected, input, 1, cache lookup missed this cycle. Sampled only in IDLE.
- miss_address, input, ADDR_W, byte address that missed.
- fsm_busy, output, 1, stall request to the pipeline (PC write, IF/ID and ID/EX enables).
- memory_req, output, 1, read request to main memory this cycle.
- memory_address, output, ADDR_W, word address of the current request.
- memory_data_valid, input, 1, main memory returns a word this cycle.
- memory_data, input, 16, returned word.
- write_data_array, output, 1, write fill_data into data array word fill_word.
- fill_word, output, log2(WORDS), word offset of the current data-array write.
- fill_data, output, 16, data for the data array. Equals memory_data.
- write_tag_array, output, 1, write tag/valid for the filled block. Single-cycle pulse.
- fill_done, output, 1, block complete. Same cycle as write_tag_array.

Behaviour:
- Reset: clk and rst_n as named; reset is asynchronous, active-low. On reset the FSM goes to IDLE and the issue/receive counters and latched base are cleared. All outputs are 0 while rst_n is low and in IDLE with miss_detected=0.
- States: IDLE and FILL.
- IDLE:
  - fsm_busy = miss_detected (combinational), so the miss cycle is already stalled.
  - On a clock edge with miss_detected=1: latch base = miss_address with bits [log2(WORDS):0] cleared, clear both counters, go to FILL.
- FILL, issue side:
  - While issue_cnt < WORDS: memory_req=1 and memory_address = base | (issue_cnt<<1). issue_cnt increments each cycle.
  - The first request occurs in the first FILL cycle (cycle 0 after entry).
  - After WORDS requests: memory_req=0 and memory_address=0.
  - Memory is pipelined and needs no backpressure.
- FILL, receive side:
  - Each cycle with memory_data_valid=1 and recv_cnt < WORDS: write_data_array=1, fill_word=recv_cnt, fill_data=memory_data, then recv_cnt increments.
  - Data arrives in request order. Gaps between valids are allowed.
  - memory_data_valid is ignored in IDLE and after recv_cnt reaches WORDS.
- Completion:
  - In the cycle the last word (recv_cnt = WORDS-1) is accepted, write_data_array, write_tag_array and fill_done are all 1.
  - The next state is IDLE.
- fsm_busy = 1 throughout FILL, including the completion cycle. It drops in the first IDLE cycle unless a new miss_detected is asserted.
- miss_detected and miss_address are ignored during FILL; base stays stable.
- Nominal timing (memory latency L=4, valid for word k in FILL cycle k+L-1):
  - Last word arrives in FILL cycle 10.
  - Busy lasts the detect cycle + 11 FILL cycles = 12 cycles.
- Back-to-back: if miss_detected=1 in the first IDLE cycle after completion, a new FILL starts on that edge. No dead cycle is required beyond that IDLE cycle.
- Reset mid-fill: the fill is abandoned immediately. No tag write occurs and the partial block stays invalid, because the tag is never written.
- Counters are log2(WORDS)+1 bits wide so the terminal value WORDS is representable. No wrap-around.

Test Plan:
- Single miss at 0x1236, memory model L=4:
  - memory_address sequence is 0x1230, 0x1232, …, 0x123E on FILL cycles 0–7.
  - fill_word goes 0..7 with matching data.
  - write_tag_array and fill_done pulse once in FILL cycle 10.
  - fsm_busy is high for exactly 12 cycles.
- Memory stall: delay word 3's valid by 2 cycles. Data still lands at fill_word 3, and completion slips to FILL cycle 12 with exactly 8 data writes.
- Spurious memory_data_valid in IDLE, plus extra valids after completion: no data or tag writes, and state stays IDLE.
- miss_detected held high with miss_address changing to 0x4000 during a fill at 0x1230:
  - The fill completes for 0x1230.
  - A second fill to 0x4000 starts the cycle after completion, first request 0x4000.
- rst_n pulsed low in FILL cycle 5:
  - All outputs go to 0 immediately (asynchronous). No write_tag_array.
  - After release, a miss at 0x00F0 fills cleanly from 0x00F0.
- Miss at 0xFFFE: base is 0xFFF0 and the last address is 0xFFFE, with no overflow into the next block.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: stalls the pipeline, streams one block from
// pipelined main memory into the data array, then writes the tag array.
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_detected,
  input  logic [ADDR_W-1:0]        miss_address,
  output logic                     fsm_busy,
  output logic                     memory_req,
  output logic [ADDR_W-1:0]        memory_address,
  input  logic                     memory_data_valid,
  input  logic [15:0]              memory_data,
  output logic                     write_data_array,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic [15:0]              fill_data,
  output logic                     write_tag_array,
  output logic                     fill_done
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(WORDS - 1);
  // Clears the word offset and the byte-within-word bit.
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~(ADDR_W'(2 * WORDS - 1));

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  issue_cnt_reg, issue_cnt_next;
  logic [CNT_W-1:0]  recv_cnt_reg, recv_cnt_next;
  logic [ADDR_W-1:0] base_reg, base_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      issue_cnt_reg <= '0;
      recv_cnt_reg  <= '0;
      base_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      issue_cnt_reg <= issue_cnt_next;
      recv_cnt_reg  <= recv_cnt_next;
      base_reg      <= base_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    issue_cnt_next   = issue_cnt_reg;
    recv_cnt_next    = recv_cnt_reg;
    base_next        = base_reg;
    fsm_busy         = 1'b0;
    memory_req       = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word        = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;

    case (state_reg)
      IDLE: begin
        // Stall the miss cycle itself; keep quiet while reset is held.
        fsm_busy = miss_detected & rst_n;
        if (miss_detected) begin
          state_next     = FILL;
          base_next      = miss_address & BLOCK_MASK;
          issue_cnt_next = '0;
          recv_cnt_next  = '0;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt_reg < CNT_FULL) begin
          memory_req     = 1'b1;
          memory_address = base_reg | ADDR_W'({issue_cnt_reg[OFF_W-1:0], 1'b0});
          issue_cnt_next = issue_cnt_reg + 1'b1;
        end
        // Memory returns words in request order, so recv_cnt is the word offset.
        if (memory_data_valid && (recv_cnt_reg < CNT_FULL)) begin
          write_data_array = 1'b1;
          fill_word        = recv_cnt_reg[OFF_W-1:0];
          fill_data        = memory_data;
          recv_cnt_next    = recv_cnt_reg + 1'b1;
          if (recv_cnt_reg == CNT_LAST) begin
            write_tag_array = 1'b1;
            fill_done       = 1'b1;
            state_next      = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized and directed bench for cache_fill_fsm against a queue-based
// block-fill reference model and a pipelined main-memory model.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        memory_req;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic        fill_done;

  always #5 clk = ~clk;

  cache_fill_fsm #(.ADDR_W(16), .WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .fsm_busy(fsm_busy), .memory_req(memory_req), .memory_address(memory_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .write_data_array(write_data_array), .fill_word(fill_word), .fill_data(fill_data),
    .write_tag_array(write_tag_array), .fill_done(fill_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Main memory contents as a pure function of the word address.
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a ^ 16'h5A5A) + {a[7:0], a[15:8]};
  endfunction

  typedef struct {int ready; logic [15:0] data;} resp_t;
  resp_t       mem_q[$];
  int          last_ready = 0;
  bit          stall_mode = 0, gap_mode = 0, spur = 0;

  // Reference model: pending request addresses and words received for the block.
  logic [15:0] req_q[$];
  bit          m_fill = 0;
  logic [15:0] m_base = '0;
  int          m_wr = 0, m_fcyc = 0;

  // Observations for directed checks.
  int          n_wr, n_tag, tag_fcyc, busy_run = 0, busy_len;
  logic [15:0] first_addr, last_addr;
  int          tag_cycs[$], first_cycs[$];

  task automatic clear_stats();
    n_wr = 0; n_tag = 0; tag_fcyc = -1; busy_len = 0;
    first_addr = '0; last_addr = '0;
    tag_cycs.delete(); first_cycs.delete();
  endtask

  task automatic step(input logic miss, input logic [15:0] addr, input bit do_rst);
    logic        e_busy, e_req, e_wr, e_tag;
    logic [15:0] e_addr, e_data;
    logic [2:0]  e_word;
    int          r;
    @(posedge clk);
    #1;
    cyc++;
    miss_detected = miss;
    miss_address  = addr;
    if (do_rst) rst_n = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      memory_data_valid = 1'b1;
      memory_data       = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      memory_data_valid = spur && !m_fill && ($urandom_range(0, 1) == 1);
      memory_data       = 16'($urandom);
    end

    e_busy = 0; e_req = 0; e_wr = 0; e_tag = 0; e_addr = '0; e_data = '0; e_word = '0;
    if (!do_rst) begin
      if (!m_fill) e_busy = miss;
      else begin
        e_busy = 1'b1;
        if (req_q.size() > 0) begin
          e_req  = 1'b1;
          e_addr = req_q[0];
        end
        if (memory_data_valid && m_wr < 8) begin
          e_wr   = 1'b1;
          e_word = 3'(m_wr);
          e_data = mem_fn(m_base + 16'(2 * m_wr));
          e_tag  = (m_wr == 7);
        end
      end
    end

    @(negedge clk);
    check_eq("fsm_busy", fsm_busy, e_busy);
    check_eq("memory_req", memory_req, e_req);
    check_eq("memory_address", memory_address, e_addr);
    check_eq("write_data_array", write_data_array, e_wr);
    check_eq("fill_word", fill_word, e_word);
    check_eq("fill_data", fill_data, e_data);
    check_eq("write_tag_array", write_tag_array, e_tag);
    check_eq("fill_done", fill_done, e_tag);

    if (write_data_array) n_wr++;
    if (write_tag_array) begin
      n_tag++;
      tag_fcyc = m_fcyc;
      tag_cycs.push_back(cyc);
    end
    if (memory_req) begin
      if (m_fcyc == 0) begin
        first_addr = memory_address;
        first_cycs.push_back(cyc);
      end
      last_addr = memory_address;
      r = cyc + 3;
      if (r <= last_ready) r = last_ready + 1;
      if (stall_mode && m_fcyc == 3) r += 2;
      if (gap_mode) r += $urandom_range(0, 2);
      last_ready = r;
      mem_q.push_back('{ready: r, data: mem_fn(memory_address)});
    end
    if (fsm_busy) busy_run++;
    else if (busy_run > 0) begin
      busy_len = busy_run;
      busy_run = 0;
    end

    if (do_rst) begin
      m_fill = 0;
      req_q.delete();
      mem_q.delete();
      last_ready = 0;
      miss_detected = 1'b0;
      memory_data_valid = 1'b0;
      rst_n = 1'b1;
    end else if (!m_fill) begin
      if (miss) begin
        m_fill = 1;
        m_base = addr & 16'hFFF0;
        req_q.delete();
        for (int k = 0; k < 8; k++) req_q.push_back(m_base + 16'(2 * k));
        m_wr = 0;
        m_fcyc = 0;
      end
    end else begin
      if (req_q.size() > 0) void'(req_q.pop_front());
      if (e_wr) m_wr++;
      if (e_tag) m_fill = 0;
      m_fcyc++;
    end
    $display("cyc %0d miss=%0b busy=%0b req=%0b addr=%h wr=%0b word=%0d data=%h tag=%0b",
             cyc, miss, fsm_busy, memory_req, memory_address, write_data_array,
             fill_word, fill_data, write_tag_array);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; miss_detected = 1'b0; miss_address = '0;
    memory_data_valid = 1'b0; memory_data = '0;
    clear_stats();

    // Reset with a miss pending: every output must stay low.
    step(1'b1, 16'h1236, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    idle(2);

    // Nominal single miss.
    clear_stats();
    step(1'b1, 16'h1236, 1'b0);
    idle(14);
    check_eq("t1_writes", n_wr, 8);
    check_eq("t1_tags", n_tag, 1);
    check_eq("t1_tag_fill_cycle", tag_fcyc, 10);
    check_eq("t1_busy_len", busy_len, 12);
    check_eq("t1_first_addr", first_addr, 16'h1230);
    check_eq("t1_last_addr", last_addr, 16'h123E);

    // Word 3 delayed by two cycles, spurious valids after completion.
    clear_stats();
    stall_mode = 1; spur = 1;
    step(1'b1, 16'h0AB4, 1'b0);
    idle(20);
    check_eq("stall_writes", n_wr, 8);
    check_eq("stall_tags", n_tag, 1);
    check_eq("stall_tag_fill_cycle", tag_fcyc, 12);
    stall_mode = 0;

    // Spurious valids in IDLE only.
    clear_stats();
    idle(8);
    check_eq("spur_writes", n_wr, 0);
    check_eq("spur_tags", n_tag, 0);
    spur = 0;

    // Miss held high with a changing address: back-to-back fills.
    clear_stats();
    step(1'b1, 16'h1230, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 16'h4000, 1'b0);
    idle(14);
    check_eq("b2b_tags", n_tag, 2);
    check_eq("b2b_writes", n_wr, 16);
    check_eq("b2b_first_addr", first_addr, 16'h4000);
    check_eq("b2b_busy_len", busy_len, 24);
    if (tag_cycs.size() >= 1 && first_cycs.size() >= 2)
      check_eq("b2b_gap", first_cycs[1] - tag_cycs[0], 2);
    else
      check_eq("b2b_event_count", tag_cycs.size() * 16 + first_cycs.size(), 16 + 2);

    // Reset in FILL cycle 5, then a clean fill.
    clear_stats();
    step(1'b1, 16'h1236, 1'b0);
    idle(5);
    step(1'b0, 16'h0000, 1'b1);
    idle(10);
    check_eq("rst_tags", n_tag, 0);
    check_eq("rst_partial_writes", n_wr, 2);
    clear_stats();
    step(1'b1, 16'h00F0, 1'b0);
    idle(14);
    check_eq("post_rst_first_addr", first_addr, 16'h00F0);
    check_eq("post_rst_last_addr", last_addr, 16'h00FE);
    check_eq("post_rst_tags", n_tag, 1);
    check_eq("post_rst_writes", n_wr, 8);

    // Top-of-memory block.
    clear_stats();
    step(1'b1, 16'hFFFE, 1'b0);
    idle(14);
    check_eq("top_first_addr", first_addr, 16'hFFF0);
    check_eq("top_last_addr", last_addr, 16'hFFFE);
    check_eq("top_writes", n_wr, 8);
    check_eq("top_tags", n_tag, 1);

    // Random traffic: gaps, spurious IDLE valids, stray misses, rare resets.
    gap_mode = 1;
    for (int it = 0; it < 30; it++) begin
      spur = ($urandom_range(0, 1) == 1);
      step(1'b1, 16'($urandom), 1'b0);
      for (int j = 0; j < 40; j++)
        step($urandom_range(0, 7) == 0, 16'($urandom), $urandom_range(0, 99) == 0);
    end
    gap_mode = 0; spur = 0;
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
